// File: rtl/shift_reg_burst_pkg.sv
// Shared types and the single-step shift function for the burst shift register.
package shift_pkg;

    localparam int SHIFT_MAX_W = 64;

    typedef enum logic [1:0] {
        SHR = 2'd0,
        SHL = 2'd1,
        ROR = 2'd2,
        ASR = 2'd3
    } shift_mode_t;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } burst_state_t;

    // Data is carried zero-extended to SHIFT_MAX_W; w is the live register width.
    function automatic logic [SHIFT_MAX_W-1:0] shift_step(
        input logic [SHIFT_MAX_W-1:0] data,
        input int unsigned            w,
        input shift_mode_t            mode,
        input logic                   sin
    );
        logic [SHIFT_MAX_W-1:0] mask;
        logic [SHIFT_MAX_W-1:0] res;
        logic                   msb;
        mask = ~({SHIFT_MAX_W{1'b1}} << w);
        msb  = |(data & ({{(SHIFT_MAX_W-1){1'b0}}, 1'b1} << (w - 1)));
        res  = data >> 1;
        case (mode)
            SHR:     res = res | ({{(SHIFT_MAX_W-1){1'b0}}, sin} << (w - 1));
            SHL:     res = (data << 1) | {{(SHIFT_MAX_W-1){1'b0}}, sin};
            ROR:     res = res | ({{(SHIFT_MAX_W-1){1'b0}}, data[0]} << (w - 1));
            ASR:     res = res | ({{(SHIFT_MAX_W-1){1'b0}}, msb} << (w - 1));
            default: res = data;
        endcase
        return res & mask;
    endfunction

endpackage

// File: rtl/shift_reg_burst_if.sv
// Control/data bundle between a driver and the burst shift register.
interface shift_reg_burst_if
    import shift_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
);
    logic              Load;
    logic [WIDTH-1:0]  D;
    shift_mode_t       Mode;
    logic              Shift_En;
    logic              Start;
    logic [CNT_W-1:0]  Count;
    logic              Shift_In;
    logic              Busy;
    logic              Done;
    logic              Shift_Out;
    logic [WIDTH-1:0]  Data_Out;

    modport master (
        output Load, D, Mode, Shift_En, Start, Count, Shift_In,
        input  Busy, Done, Shift_Out, Data_Out
    );

    modport slave (
        input  Load, D, Mode, Shift_En, Start, Count, Shift_In,
        output Busy, Done, Shift_Out, Data_Out
    );
endinterface

// File: rtl/shift_reg_burst_ctrl.sv
// Burst sequencer: IDLE/RUN FSM, remaining-shift counter with clamp, Busy/Done,
// and the per-edge step enable plus the mode that step should use.
module shift_burst_ctrl
    import shift_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic             start_i,
    input  logic             shift_en_i,
    input  logic [CNT_W-1:0] count_i,
    input  shift_mode_t      mode_i,
    output logic             step_en_o,
    output logic             busy_o,
    output logic             done_o,
    output shift_mode_t      mode_o
);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(WIDTH);

    burst_state_t     state_q, state_d;
    logic [CNT_W-1:0] remaining_q, remaining_d;
    shift_mode_t      mode_q, mode_d;
    logic             done_q, done_d;
    logic [CNT_W-1:0] count_clamped_s;

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            remaining_q <= {CNT_W{1'b0}};
            mode_q      <= SHR;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            mode_q      <= mode_d;
            done_q      <= done_d;
        end
    end

    // Next-state: Load aborts or blocks a burst; Start only acts from IDLE.
    always_comb begin
        state_d         = state_q;
        remaining_d     = remaining_q;
        mode_d          = mode_q;
        done_d          = 1'b0;
        count_clamped_s = (count_i > MAX_CNT) ? MAX_CNT : count_i;
        case (state_q)
            IDLE: begin
                if (load_i) begin
                    state_d = IDLE;
                end else if (start_i) begin
                    if (count_clamped_s != {CNT_W{1'b0}}) begin
                        state_d     = RUN;
                        remaining_d = count_clamped_s;
                        mode_d      = mode_i;
                    end else begin
                        done_d = 1'b1;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (load_i) begin
                    state_d     = IDLE;
                    remaining_d = {CNT_W{1'b0}};
                end else begin
                    remaining_d = remaining_q - CNT_W'(1);
                    if (remaining_q == CNT_W'(1)) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            default: begin
                state_d     = IDLE;
                remaining_d = {CNT_W{1'b0}};
            end
        endcase
    end

    // Outputs: a single step in IDLE only when neither Load nor Start claims the edge.
    always_comb begin
        busy_o    = (state_q == RUN);
        done_o    = done_q;
        mode_o    = (state_q == RUN) ? mode_q : mode_i;
        step_en_o = 1'b0;
        if (state_q == RUN) begin
            step_en_o = ~load_i;
        end else begin
            step_en_o = shift_en_i & ~start_i & ~load_i;
        end
    end

endmodule

// File: rtl/shift_reg_burst.sv
// Universal shift register with parallel load and a counted burst sequencer.
module shift_reg_burst
    import shift_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
    input  logic             Clk,
    input  logic             Reset,
    shift_reg_burst_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [WIDTH-1:0]       data_q, data_d;
    logic [SHIFT_MAX_W-1:0] step_wide_s;
    logic                   step_en_s;
    logic                   busy_s;
    logic                   done_s;
    shift_mode_t            active_mode_s;

    shift_burst_ctrl #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_ctrl (
        .clk_i      (Clk),
        .rst_i      (Reset),
        .load_i     (bus.Load),
        .start_i    (bus.Start),
        .shift_en_i (bus.Shift_En),
        .count_i    (bus.Count),
        .mode_i     (bus.Mode),
        .step_en_o  (step_en_s),
        .busy_o     (busy_s),
        .done_o     (done_s),
        .mode_o     (active_mode_s)
    );

    assign step_wide_s = shift_step(SHIFT_MAX_W'(data_q), WIDTH, active_mode_s, bus.Shift_In);

    // Data register next value: Load beats any shift step.
    always_comb begin
        data_d = data_q;
        if (bus.Load) begin
            data_d = bus.D;
        end else if (step_en_s) begin
            data_d = step_wide_s[WIDTH-1:0];
        end else begin
            data_d = data_q;
        end
    end

    // Data register.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            data_q <= RESET_VAL;
        end else begin
            data_q <= data_d;
        end
    end

    assign bus.Data_Out  = data_q;
    assign bus.Busy      = busy_s;
    assign bus.Done      = done_s;
    assign bus.Shift_Out = (active_mode_s == SHL) ? data_q[WIDTH-1] : data_q[0];

endmodule
